// File: rtl/opb_register_simulink2ppc_snap_pkg.sv
// Shared definitions for the OPB slave register family.
// Contents: word index constants, status bit positions (OPB big-endian
// numbering, so bit 31 is the LSB) and the ack sequencer state type.
package opb_reg_pkg;

  localparam logic [1:0] IDX_DATA   = 2'd0;
  localparam logic [1:0] IDX_STATUS = 2'd1;
  localparam logic [1:0] IDX_TSTAMP = 2'd2;

  localparam int NEW_DATA_BIT = 31;
  localparam int OVERRUN_BIT  = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } ack_state_t;

endpackage

// File: rtl/opb_register_simulink2ppc_snap_if.sv
// OPB bus bundle between a master and one slave.
// Master drives address/data/control (OPB_*); slave returns Sl_* data and
// status. Buses use OPB big-endian bit numbering [0:31].
interface opb_register_simulink2ppc_snap_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave address decode and one-shot ack sequencing (IDLE/ACK/WAIT).
// Ports: clk/rst, abus/select in; hit_idx (live word index), load (IDLE->ACK
// strobe), ack_pulse (registered 1-cycle ack), ack_idx (index of acked word).
module opb_slave_ack_fsm
  import opb_reg_pkg::*;
#(
  parameter int                      C_OPB_AWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h0110C500,
  parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h0110C5FF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [0:C_OPB_AWIDTH-1] abus,
  input  logic                  select,
  output logic [1:0]            hit_idx,
  output logic                  load,
  output logic                  ack_pulse,
  output logic [1:0]            ack_idx
);

  ack_state_t state;
  logic       hit;

  assign hit     = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign hit_idx = abus[C_OPB_AWIDTH-4:C_OPB_AWIDTH-3];
  assign load    = (state == IDLE) && hit;

  // WAIT holds off until select drops so a held select is acked only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ack_pulse <= 1'b0;
      ack_idx   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state     <= ACK;
            ack_pulse <= 1'b1;
            ack_idx   <= hit_idx;
          end
        end
        ACK: begin
          state     <= WAIT;
          ack_pulse <= 1'b0;
        end
        WAIT: begin
          if (!select) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          ack_pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB read-only snapshot register: fabric writes a word, PPC reads it.
// Ports: OPB_Clk/OPB_Rst, opb slave bus; user_data_in/user_valid capture,
// user_new_data mirrors the status new-data flag.
// Optional timestamp (macro SIMULINK2PPC_TSTAMP_EN): word 2 returns the
// free-running cycle count captured with each user_valid.
module opb_register_simulink2ppc_snap
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0110C500,
  parameter logic [31:0] C_HIGHADDR   = 32'h0110C5FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                                OPB_Clk,
  input  logic                                OPB_Rst,
  opb_register_simulink2ppc_snap_if.slave     opb,
  input  logic [31:0]                         user_data_in,
  input  logic                                user_valid,
  output logic                                user_new_data
);

  logic [31:0]             data_reg;
  logic                    new_data;
  logic                    overrun;
  logic [0:C_OPB_DWIDTH-1] rd_next;
  logic [0:C_OPB_DWIDTH-1] rd_data;
  logic [1:0]              hit_idx;
  logic [1:0]              ack_idx;
  logic                    load;
  logic                    ack_pulse;
  logic                    status_clr;

  // Byte enables, write data, seqAddr and the family string are not needed.
  wire unused_bus = &{1'b0, opb.OPB_BE, opb.OPB_DBus, opb.OPB_seqAddr};
  wire [7:0] unused_family = 8'(C_FAMILY);

  opb_slave_ack_fsm #(
    .C_OPB_AWIDTH (C_OPB_AWIDTH),
    .C_BASEADDR   (C_BASEADDR[C_OPB_AWIDTH-1:0]),
    .C_HIGHADDR   (C_HIGHADDR[C_OPB_AWIDTH-1:0])
  ) u_ack_fsm (
    .clk       (OPB_Clk),
    .rst       (OPB_Rst),
    .abus      (opb.OPB_ABus),
    .select    (opb.OPB_select),
    .hit_idx   (hit_idx),
    .load      (load),
    .ack_pulse (ack_pulse),
    .ack_idx   (ack_idx)
  );

`ifdef SIMULINK2PPC_TSTAMP_EN
  logic [31:0] cycle_cnt;
  logic [31:0] tstamp_reg;

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      cycle_cnt  <= 32'd0;
      tstamp_reg <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (user_valid) tstamp_reg <= cycle_cnt;
    end
  end
`endif

  always_comb begin
    rd_next = '0;
    case (hit_idx)
      IDX_DATA:   rd_next = data_reg;
      IDX_STATUS: begin
        rd_next[NEW_DATA_BIT] = new_data;
        rd_next[OVERRUN_BIT]  = overrun;
      end
`ifdef SIMULINK2PPC_TSTAMP_EN
      IDX_TSTAMP: rd_next = tstamp_reg;
`endif
      default:    rd_next = '0;
    endcase
  end

  // Read data is frozen at IDLE->ACK so later captures never alter it.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) rd_data <= '0;
    else if (load) rd_data <= rd_next;
  end

  assign status_clr = ack_pulse && opb.OPB_RNW && (ack_idx == IDX_STATUS);

  // A capture in the clear cycle wins for new_data; overrun only sets when
  // the previous word is still unread and not being read right now.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      data_reg <= 32'd0;
      new_data <= 1'b0;
      overrun  <= 1'b0;
    end else if (user_valid) begin
      data_reg <= user_data_in;
      new_data <= 1'b1;
      overrun  <= status_clr ? 1'b0 : (overrun | new_data);
    end else if (status_clr) begin
      new_data <= 1'b0;
      overrun  <= 1'b0;
    end
  end

  assign opb.Sl_DBus    = (ack_pulse && opb.OPB_RNW) ? rd_data : '0;
  assign opb.Sl_xferAck = ack_pulse;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;
  assign user_new_data  = new_data;

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
module tb_opb_register_simulink2ppc_snap;

  localparam logic [31:0] A_DATA   = 32'h0110C500;
  localparam logic [31:0] A_STATUS = 32'h0110C504;
  localparam logic [31:0] A_TSTAMP = 32'h0110C508;
  localparam logic [31:0] A_IDX3   = 32'h0110C5FC;
  localparam logic [31:0] A_ABOVE  = 32'h0110C600;
  localparam logic [31:0] A_BELOW  = 32'h0110C4FC;

  logic        clk;
  logic        rst;
  logic [31:0] user_data_in;
  logic        user_valid;
  logic        user_new_data;

  opb_register_simulink2ppc_snap_if bus ();

  opb_register_simulink2ppc_snap dut (
    .OPB_Clk       (clk),
    .OPB_Rst       (rst),
    .opb           (bus),
    .user_data_in  (user_data_in),
    .user_valid    (user_valid),
    .user_new_data (user_new_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count: cleared by reset, +1 per clock.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  // Bench-side register model.
  logic [31:0] m_data = 32'd0;
  logic        m_nd = 1'b0;
  logic        m_ov = 1'b0;
  logic [31:0] m_ts = 32'd0;

  int acks, lat;
  logic [31:0] dat, dor, e;

  // Caller is at posedge+1. Returns at posedge+1 with the FSM back in IDLE.
  task automatic opb_xfer(input logic [31:0] a, input logic rnw, input int hold,
                          output int n_ack, output int first, output logic [31:0] d,
                          output logic [31:0] d_idle);
    n_ack = 0; first = -1; d = '0; d_idle = '0;
    bus.OPB_ABus = a; bus.OPB_RNW = rnw; bus.OPB_select = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk); #1;
      if (bus.Sl_xferAck === 1'b1) begin
        n_ack++;
        if (first < 0) begin first = i; d = bus.Sl_DBus; end
      end else begin
        d_idle = d_idle | bus.Sl_DBus;
      end
    end
    bus.OPB_select = 1'b0; bus.OPB_ABus = '0; bus.OPB_RNW = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic usr(input logic [31:0] v);
    m_ov = m_ov | m_nd;
    m_nd = 1'b1;
    m_data = v;
`ifdef SIMULINK2PPC_TSTAMP_EN
    m_ts = cyc;
`endif
    user_valid = 1'b1; user_data_in = v;
    @(posedge clk); #1;
    user_valid = 1'b0; user_data_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (bus.Sl_xferAck !== 1'b0 || bus.Sl_DBus !== 32'd0 || user_new_data !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b dbus=%h nd=%b, want 0 0 0",
               bus.Sl_xferAck, bus.Sl_DBus, user_new_data);
    end
    n_chk++;
    if ({bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_consts: err/retry/tout=%b, want 000",
               {bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    // Reset asserted while ack is high must drop it without a clock edge.
    bus.OPB_ABus = A_DATA; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (bus.Sl_xferAck !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_ack_before: ack=%b, want 1", bus.Sl_xferAck);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (bus.Sl_xferAck !== 1'b0 || bus.Sl_DBus !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_async_drop: ack=%b dbus=%h, want 0 0",
               bus.Sl_xferAck, bus.Sl_DBus);
    end
    bus.OPB_select = 1'b0; bus.OPB_ABus = '0; bus.OPB_RNW = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_reads();
    exp_q.push_back(m_data);
    opb_xfer(A_DATA, 1'b1, 2, acks, lat, dat, dor);
    e = exp_q.pop_front();
    n_chk++;
    if (acks !== 1 || lat !== 1 || dat !== e) begin
      n_fail++;
      $display("FAIL idle_data: acks=%0d lat=%0d dat=%h, want 1 1 %h", acks, lat, dat, e);
    end
    exp_q.push_back({30'd0, m_ov, m_nd});
    opb_xfer(A_STATUS, 1'b1, 2, acks, lat, dat, dor);
    e = exp_q.pop_front();
    n_chk++;
    if (acks !== 1 || lat !== 1 || dat !== e) begin
      n_fail++;
      $display("FAIL idle_status: acks=%0d lat=%0d dat=%h, want 1 1 %h", acks, lat, dat, e);
    end
  endtask

  task automatic test_tstamp();
    int waited = 0;
    while (cyc < 100 && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    if (cyc != 100) begin
      n_chk++; n_fail++;
      $display("FAIL tstamp_align: counter ref=%0d, want 100", cyc);
    end
    usr(32'h0000_0077);
`ifdef SIMULINK2PPC_TSTAMP_EN
    exp_q.push_back(m_ts);
`else
    exp_q.push_back(32'd0);
`endif
    opb_xfer(A_TSTAMP, 1'b1, 2, acks, lat, dat, dor);
    e = exp_q.pop_front();
    n_chk++;
    if (acks !== 1 || dat !== e) begin
      n_fail++;
      $display("FAIL tstamp_read: acks=%0d dat=%0d, want 1 %0d", acks, dat, e);
    end
    exp_q.push_back({30'd0, m_ov, m_nd});
    opb_xfer(A_STATUS, 1'b1, 2, acks, lat, dat, dor);
    e = exp_q.pop_front();
    m_nd = 1'b0; m_ov = 1'b0;
    n_chk++;
    if (acks !== 1 || dat !== e) begin
      n_fail++;
      $display("FAIL tstamp_status: acks=%0d dat=%h, want 1 %h", acks, dat, e);
    end
  endtask

  task automatic test_capture();
    usr(32'hDEADBEEF);
    exp_q.push_back(m_data);
    opb_xfer(A_DATA, 1'b1, 2, acks, lat, dat, dor);
    e = exp_q.pop_front();
    n_chk++;
    if (acks !== 1 || lat !== 1 || dat !== e) begin
      n_fail++;
      $display("FAIL capture_data: acks=%0d lat=%0d dat=%h, want 1 1 %h", acks, lat, dat, e);
    end
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({30'd0, m_ov, m_nd});
      opb_xfer(A_STATUS, 1'b1, 2, acks, lat, dat, dor);
      e = exp_q.pop_front();
      m_nd = 1'b0; m_ov = 1'b0;
      n_chk++;
      if (acks !== 1 || dat !== e) begin
        n_fail++;
        $display("FAIL capture_status%0d: acks=%0d dat=%h, want 1 %h", k, acks, dat, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    usr(32'h0000_0001);
    usr(32'h0000_0002);
    exp_q.push_back({30'd0, m_ov, m_nd});
    opb_xfer(A_STATUS, 1'b1, 2, acks, lat, dat, dor);
    e = exp_q.pop_front();
    m_nd = 1'b0; m_ov = 1'b0;
    n_chk++;
    if (acks !== 1 || dat !== e) begin
      n_fail++;
      $display("FAIL b2b_status: acks=%0d dat=%h, want 1 %h", acks, dat, e);
    end
    n_chk++;
    if (user_new_data !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_nd_cleared: user_new_data=%b, want 0", user_new_data);
    end
    exp_q.push_back(m_data);
    opb_xfer(A_DATA, 1'b1, 2, acks, lat, dat, dor);
    e = exp_q.pop_front();
    n_chk++;
    if (acks !== 1 || dat !== e) begin
      n_fail++;
      $display("FAIL b2b_data: acks=%0d dat=%h, want 1 %h", acks, dat, e);
    end
  endtask

  task automatic test_same_cycle();
    usr(32'h0000_0055);
    exp_q.push_back({30'd0, m_ov, m_nd});
    fork
      opb_xfer(A_STATUS, 1'b1, 2, acks, lat, dat, dor);
      begin
        @(posedge clk); #1;
        user_valid = 1'b1; user_data_in = 32'h0000_0066;
        @(posedge clk); #1;
        user_valid = 1'b0; user_data_in = '0;
      end
    join
    e = exp_q.pop_front();
    // Set wins over the clear; overrun does not set because of the clear.
    m_data = 32'h0000_0066; m_nd = 1'b1; m_ov = 1'b0;
    n_chk++;
    if (acks !== 1 || dat !== e) begin
      n_fail++;
      $display("FAIL same_status_prior: acks=%0d dat=%h, want 1 %h", acks, dat, e);
    end
    n_chk++;
    if (user_new_data !== 1'b1) begin
      n_fail++;
      $display("FAIL same_nd_kept: user_new_data=%b, want 1", user_new_data);
    end
    exp_q.push_back({30'd0, m_ov, m_nd});
    opb_xfer(A_STATUS, 1'b1, 2, acks, lat, dat, dor);
    e = exp_q.pop_front();
    m_nd = 1'b0; m_ov = 1'b0;
    n_chk++;
    if (acks !== 1 || dat !== e) begin
      n_fail++;
      $display("FAIL same_status_after: acks=%0d dat=%h, want 1 %h", acks, dat, e);
    end
    exp_q.push_back(m_data);
    opb_xfer(A_DATA, 1'b1, 2, acks, lat, dat, dor);
    e = exp_q.pop_front();
    n_chk++;
    if (acks !== 1 || dat !== e) begin
      n_fail++;
      $display("FAIL same_data: acks=%0d dat=%h, want 1 %h", acks, dat, e);
    end
  endtask

  task automatic test_bus_edges();
    exp_q.push_back(m_data);
    opb_xfer(A_DATA, 1'b1, 5, acks, lat, dat, dor);
    e = exp_q.pop_front();
    n_chk++;
    if (acks !== 1 || lat !== 1 || dat !== e) begin
      n_fail++;
      $display("FAIL held_select: acks=%0d lat=%0d dat=%h, want 1 1 %h", acks, lat, dat, e);
    end
    bus.OPB_DBus = 32'hFFFF_FFFF; bus.OPB_BE = 4'hF;
    opb_xfer(A_DATA, 1'b0, 2, acks, lat, dat, dor);
    bus.OPB_DBus = '0; bus.OPB_BE = '0;
    n_chk++;
    if (acks !== 1 || lat !== 1 || dat !== 32'd0) begin
      n_fail++;
      $display("FAIL write_ack: acks=%0d lat=%0d dbus=%h, want 1 1 00000000", acks, lat, dat);
    end
    exp_q.push_back(m_data);
    opb_xfer(A_DATA, 1'b1, 2, acks, lat, dat, dor);
    e = exp_q.pop_front();
    n_chk++;
    if (acks !== 1 || dat !== e) begin
      n_fail++;
      $display("FAIL write_no_effect: acks=%0d dat=%h, want 1 %h", acks, dat, e);
    end
    exp_q.push_back(32'd0);
    opb_xfer(A_IDX3, 1'b1, 2, acks, lat, dat, dor);
    e = exp_q.pop_front();
    n_chk++;
    if (acks !== 1 || dat !== e) begin
      n_fail++;
      $display("FAIL idx3_top: acks=%0d dat=%h, want 1 %h", acks, dat, e);
    end
    opb_xfer(A_ABOVE, 1'b1, 3, acks, lat, dat, dor);
    n_chk++;
    if (acks !== 0 || dor !== 32'd0) begin
      n_fail++;
      $display("FAIL miss_above: acks=%0d dbus=%h, want 0 00000000", acks, dor);
    end
    opb_xfer(A_BELOW, 1'b1, 3, acks, lat, dat, dor);
    n_chk++;
    if (acks !== 0 || dor !== 32'd0) begin
      n_fail++;
      $display("FAIL miss_below: acks=%0d dbus=%h, want 0 00000000", acks, dor);
    end
  endtask

  initial begin
    rst = 1'b1;
    user_valid = 1'b0; user_data_in = '0;
    bus.OPB_ABus = '0; bus.OPB_BE = '0; bus.OPB_DBus = '0;
    bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;
    test_reset();
    test_idle_reads();
    test_tstamp();
    test_capture();
    test_back_to_back();
    test_same_cycle();
    test_bus_edges();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
